// File: rtl/tetris_key_conditioner.sv
// rtl/tetris_key_conditioner.sv - KEY pushbutton synchroniser, debouncer and auto-repeat pulse generator
//
// Purpose:
//   Turns the four raw, bouncy, active-low DE2 KEY buttons into clean
//   one-cycle action pulses for the Tetris core. Each channel is
//   synchronised (2 flops), debounced (accepted state + counter) and then
//   fed to a small repeat FSM. Left/right/down auto-repeat while held,
//   and rotate fires once per press (selected by REPEAT_MASK).
//
// Ports:
//   clk_50     in   1  system clock (50 MHz)
//   reset      in   1  asynchronous active-high reset
//   key_n      in   4  raw KEY pins, active-low; bit0 right, bit1 left, bit2 down, bit3 rotate
//   pause      in   1  synchronous pause; suppresses pulses, parks FSMs in IDLE
//   btn_pulse  out  4  registered one-cycle action pulses
//   btn_level  out  4  registered debounced pressed level (1 = held)

module tetris_key_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         REPEAT_DELAY    = 15000000,
  parameter int         REPEAT_RATE     = 5000000,
  parameter logic [3:0] REPEAT_MASK     = 4'b0111,
  parameter int         CNT_W           = 24
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       pause,
  output logic [3:0] btn_pulse,
  output logic [3:0] btn_level
);

  localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HELD   = 2'd3
  } state_t;

  // Two-flop synchroniser; idles at 1 (released) so a key held through
  // reset is seen as a fresh press once reset is released.
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch

    logic [CNT_W-1:0] r_dc;
    logic             r_acc;
    logic             w_differs;
    logic             w_dc_done;
    logic             w_press_acc;
    logic             w_release_acc;
    logic             r_press_evt;
    logic             r_release_evt;
    logic             r_level;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_rc;
    logic [CNT_W-1:0] w_rc_nxt;
    logic             w_pulse_nxt;
    logic             r_pulse;

    assign w_differs     = (r_sync2[g] != r_acc);
    assign w_dc_done     = w_differs && (r_dc == DC_LAST);
    assign w_press_acc   = w_dc_done && !r_sync2[g];
    assign w_release_acc = w_dc_done &&  r_sync2[g];

    // Debounce: the counter only runs while the synchronised input
    // disagrees with the accepted state; any bounce back restarts it.
    always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
        r_dc  <= '0;
        r_acc <= 1'b1;
      end else if (!w_differs) begin
        r_dc  <= '0;
      end else if (w_dc_done) begin
        r_acc <= r_sync2[g];
        r_dc  <= '0;
      end else begin
        r_dc  <= r_dc + CNT_ONE;
      end
    end

    // Accept events are registered so the FSM and btn_level both react one
    // edge after acceptance. A press accepted while pause is high is dropped
    // here so it cannot leak out after pause falls.
    always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
        r_press_evt   <= 1'b0;
        r_release_evt <= 1'b0;
        r_level       <= 1'b0;
      end else begin
        r_press_evt   <= w_press_acc && !pause;
        r_release_evt <= w_release_acc;
        r_level       <= ~r_acc;
      end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_rc    <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_rc    <= w_rc_nxt;
        r_pulse <= w_pulse_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_rc_nxt    = r_rc;
      w_pulse_nxt = 1'b0;
      if (pause || r_release_evt) begin
        // Pause and release both park the channel; only a new press
        // accept can leave IDLE again.
        w_state_nxt = ST_IDLE;
        w_rc_nxt    = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_rc_nxt = '0;
            if (r_press_evt) begin
              w_pulse_nxt = 1'b1;
              w_state_nxt = REPEAT_MASK[g] ? ST_DELAY : ST_HELD;
            end
          end
          ST_DELAY: begin
            if (r_rc == RD_LAST) begin
              w_pulse_nxt = 1'b1;
              w_rc_nxt    = '0;
              w_state_nxt = ST_REPEAT;
            end else begin
              w_rc_nxt    = r_rc + CNT_ONE;
            end
          end
          ST_REPEAT: begin
            if (r_rc == RR_LAST) begin
              w_pulse_nxt = 1'b1;
              w_rc_nxt    = '0;
            end else begin
              w_rc_nxt    = r_rc + CNT_ONE;
            end
          end
          ST_HELD: begin
            w_rc_nxt = '0;
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_rc_nxt    = '0;
          end
        endcase
      end
    end

    assign btn_pulse[g] = r_pulse;
    assign btn_level[g] = r_level;

  end

endmodule

// File: tb/tb_tetris_key_conditioner.sv
// tb/tb_tetris_key_conditioner.sv - self-checking bench for tetris_key_conditioner

module tb_tetris_key_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic       clk_50 = 1'b0;
  logic       reset  = 1'b1;
  logic [3:0] key_n  = 4'hF;
  logic       pause  = 1'b0;
  logic [3:0] btn_pulse;
  logic [3:0] btn_level;

  always #5 clk_50 = ~clk_50;

  tetris_key_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .REPEAT_MASK     (4'b0111),
    .CNT_W           (8)
  ) dut (
    .clk_50    (clk_50),
    .reset     (reset),
    .key_n     (key_n),
    .pause     (pause),
    .btn_pulse (btn_pulse),
    .btn_level (btn_level)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a key is accepted once its last D synchronised samples
  // all disagree with the accepted state; pulses follow a timetable anchored
  // at the first pulse edge t0: t0, t0+RD, t0+RD+RR, ...
  logic [3:0] mask_v = 4'b0111;
  logic [3:0] m_a;
  logic [3:0] hist [0:D];
  bit         m_act [4];
  int         m_t0  [4];
  bit         m_prs [4];
  bit         m_rel [4];
  int         edge_n = 0;
  logic [3:0] exp_pulse;
  logic [3:0] exp_level;
  int         pcount [4];

  task automatic model_edge();
    bit stable;
    if (reset) begin
      m_a = 4'hF;
      for (int i = 0; i <= D; i++) hist[i] = 4'hF;
      for (int c = 0; c < 4; c++) begin
        m_act[c] = 0; m_prs[c] = 0; m_rel[c] = 0; m_t0[c] = 0;
      end
      exp_pulse = 4'h0;
      exp_level = 4'h0;
    end else begin
      exp_level = ~m_a;
      for (int c = 0; c < 4; c++) begin
        if (pause || m_rel[c]) m_act[c] = 0;
        else if (m_prs[c] && !m_act[c]) begin
          m_act[c] = 1;
          m_t0[c]  = edge_n;
        end
        exp_pulse[c] = m_act[c] && ((edge_n == m_t0[c]) ||
                       (mask_v[c] && edge_n >= m_t0[c] + RD && ((edge_n - m_t0[c] - RD) % RR) == 0));
        stable = 1;
        for (int i = 1; i <= D; i++) if (hist[i][c] == m_a[c]) stable = 0;
        m_prs[c] = 0;
        m_rel[c] = 0;
        if (stable) begin
          m_a[c]   = hist[1][c];
          m_prs[c] = !m_a[c] && !pause;
          m_rel[c] = m_a[c];
        end
      end
      for (int i = D; i >= 1; i--) hist[i] = hist[i-1];
      hist[0] = key_n;
    end
    edge_n++;
  endtask

  task automatic step(input logic [3:0] k, input logic p, input logic r);
    key_n = k;
    pause = p;
    if (r && !reset) begin
      reset = 1'b1;
      #1;
      check("reset_async_pulse", btn_pulse, 4'h0);
      check("reset_async_level", btn_level, 4'h0);
    end else begin
      reset = r;
    end
    @(posedge clk_50);
    model_edge();
    @(negedge clk_50);
    check("pulse", btn_pulse, exp_pulse);
    check("level", btn_level, exp_level);
    for (int c = 0; c < 4; c++) pcount[c] += 32'(btn_pulse[c]);
  endtask

  task automatic clr_counts();
    for (int c = 0; c < 4; c++) pcount[c] = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'hF, 1'b0, 1'b0);
  endtask

  int         hold [4];
  int         phold;
  logic [3:0] kr;
  logic       pr;
  logic [3:0] k2;

  initial begin
    for (int i = 0; i < 3; i++) step(4'hF, 1'b0, 1'b1);
    idle(5);

    // clean rotate press, no repeat
    clr_counts();
    for (int e = 0; e < 60; e++) step(4'b0111, 1'b0, 1'b0);
    check("s1_count", pcount[3], 1);
    check("s1_level", 32'(btn_level[3]), 1);
    for (int e = 0; e < 10; e++) step(4'hF, 1'b0, 1'b0);
    check("s1_release_count", pcount[3], 1);
    check("s1_release_level", 32'(btn_level[3]), 0);
    idle(10);

    // bounce rejection on left
    clr_counts();
    for (int e = 0; e <= 30; e++) begin
      k2 = 4'hF;
      k2[1] = (e < 20) ? logic'((e / 2) % 2) : 1'b0;
      step(k2, 1'b0, 1'b0);
    end
    check("s2_count", pcount[1], 1);
    idle(20);

    // auto-repeat on right, release before the 46th-edge repeat
    clr_counts();
    for (int e = 0; e < 40; e++) step(4'b1110, 1'b0, 1'b0);
    for (int e = 0; e < 10; e++) step(4'hF, 1'b0, 1'b0);
    check("s3_count", pcount[0], 11);
    idle(10);

    // pause gating on down
    clr_counts();
    for (int e = 0; e < 20; e++) step(4'b1011, 1'b1, 1'b0);
    check("s4_paused_count", pcount[2], 0);
    check("s4_paused_level", 32'(btn_level[2]), 1);
    for (int e = 0; e < 20; e++) step(4'b1011, 1'b0, 1'b0);
    check("s4_unpaused_count", pcount[2], 0);
    idle(10);
    clr_counts();
    for (int e = 0; e < 10; e++) step(4'b1011, 1'b0, 1'b0);
    check("s4_repress_count", pcount[2], 1);
    idle(10);

    // simultaneous presses, then reset with keys held
    clr_counts();
    for (int e = 0; e < 12; e++) step(4'b0000, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) check("s5_count", pcount[c], 1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    clr_counts();
    for (int e = 0; e < 8; e++) step(4'b0000, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) check("s5_after_reset_count", pcount[c], 1);
    idle(10);

    // randomized bouncy keys, pause and occasional reset
    kr = 4'hF;
    pr = 1'b0;
    phold = 0;
    for (int c = 0; c < 4; c++) hold[c] = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          kr[c]   = ~kr[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 6));
        end else begin
          hold[c]--;
        end
      end
      if (phold == 0) begin
        pr    = ($urandom_range(0, 4) == 0);
        phold = $urandom_range(5, 40);
      end else begin
        phold--;
      end
      step(kr, pr, ($urandom_range(0, 999) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
